// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types, default sizes and helpers for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_DATASIZE  = 8;
  localparam int unsigned DEF_MAX_BURST = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Round-robin successor of ptr among n requesters.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side request/data bundle and memory-side write port of the arbiter.
interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned DATASIZE = DEF_DATASIZE
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req_i;
  logic [NUM_REQ*DATASIZE-1:0] data_i;
  logic                        fifo_full_i;
  logic [NUM_REQ-1:0]          gnt_o;
  logic                        wen_o;
  logic [DATASIZE-1:0]         wdata_o;
  logic [IDW-1:0]              gnt_id_o;
  logic                        busy_o;

  // Arbiter side: consumes requests, drives grant and the memory write port.
  modport master (
    input  req_i, data_i, fifo_full_i,
    output gnt_o, wen_o, wdata_o, gnt_id_o, busy_o
  );

  // Producer / environment side.
  modport slave (
    output req_i, data_i, fifo_full_i,
    input  gnt_o, wen_o, wdata_o, gnt_id_o, busy_o
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotating-priority encoder: first set request at or after rr_ptr, wrapping.
module fifo_wr_arbiter_rr_picker
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic               valid,
  output logic [IDW-1:0]     index
);

  int unsigned cand;

  // Scan from farthest to nearest offset so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = 32'd0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      cand = (32'(rr_ptr) + 32'(i)) % NUM_REQ;
      if (req[IDW'(cand)]) begin
        valid = 1'b1;
        index = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ producers,
// with bursts capped at MAX_BURST words and a mandatory idle bubble between grants.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned DATASIZE  = DEF_DATASIZE,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  fifo_wr_arbiter_if.master bus
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CW  = $clog2(MAX_BURST + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      burst_cnt_q, burst_cnt_d;

  logic                pick_valid;
  logic [IDW-1:0]      pick_idx;
  logic                holder_req;
  logic                xfer;
  logic                last_beat;
  logic [DATASIZE-1:0] holder_data;

  fifo_wr_arbiter_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (bus.req_i),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .index  (pick_idx)
  );

  // Select the grant holder's data slice.
  always_comb begin
    holder_data = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (IDW'(k) == gnt_id_q) holder_data = bus.data_i[k*DATASIZE +: DATASIZE];
    end
  end

  // A write happens only for the holder, not full, and never in a reset cycle.
  assign holder_req = bus.req_i[gnt_id_q];
  assign xfer       = rst_ni && (state_q == BURST) && holder_req && !bus.fifo_full_i;
  assign last_beat  = (burst_cnt_q == CW'(MAX_BURST - 1));

  assign bus.wen_o    = xfer;
  assign bus.wdata_o  = xfer ? holder_data : '0;
  assign bus.gnt_o    = gnt_q;
  assign bus.gnt_id_o = gnt_id_q;
  assign bus.busy_o   = (state_q == BURST);

  // Next-state: grant from IDLE, count beats in BURST, release on drop or cap.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d     = BURST;
          gnt_d       = NUM_REQ'(1) << pick_idx;
          gnt_id_d    = pick_idx;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        if (!holder_req || (xfer && last_beat)) begin
          state_d     = IDLE;
          gnt_d       = '0;
          rr_ptr_d    = IDW'(rr_next(32'(gnt_id_q), NUM_REQ));
          burst_cnt_d = '0;
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
        end
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // The memory must never be written while full or without a grant.
  a_wen_safe: assert property (@(posedge clk_i)
    !(bus.wen_o && (bus.fifo_full_i || (bus.gnt_o == '0))));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (NUM_REQ=4, DATASIZE=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  logic clk;
  logic rst_n;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATASIZE(8)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(4), .DATASIZE(8), .MAX_BURST(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic        full;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        wen;
    logic [7:0]  wdata;
    logic        busy;
    logic [1:0]  id;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } wr_t;

  vec_t tbl[$];
  wr_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   pulses;

  localparam logic [31:0] D = 32'h4433_2211;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic [3:0] req, input logic full, input logic [31:0] data);
    rst_n           = rn;
    bus.req_i       = req;
    bus.fifo_full_i = full;
    bus.data_i      = data;
  endtask

  // Drive one cycle's inputs and move to the sampling point (negedge).
  task automatic step(input logic rn, input logic [3:0] req, input logic full, input logic [31:0] data);
    drive(rn, req, full, data);
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input string tag, input logic [3:0] gnt, input logic wen,
                          input logic [7:0] wdata, input logic busy);
    chk({tag, "_gnt"},   32'(bus.gnt_o),   32'(gnt));
    chk({tag, "_wen"},   32'(bus.wen_o),   32'(wen));
    chk({tag, "_wdata"}, 32'(bus.wdata_o), 32'(wdata));
    chk({tag, "_busy"},  32'(bus.busy_o),  32'(busy));
  endtask

  function automatic void add(input logic rn, input logic [3:0] req, input logic full,
                              input logic [31:0] data, input logic [3:0] gnt, input logic wen,
                              input logic [7:0] wdata, input logic busy, input logic [1:0] id);
    vec_t v;
    v.rst_n = rn; v.req = req; v.full = full; v.data = data;
    v.gnt = gnt; v.wen = wen; v.wdata = wdata; v.busy = busy; v.id = id;
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] sl [4];
    int         order [5];
    logic [3:0] oh;
    sl    = '{8'h11, 8'h22, 8'h33, 8'h44};
    order = '{0, 1, 2, 3, 0};

    // Reset held 2 cycles with all requesting, then release; grants 0,1,2,3,0,
    // each 4 writes followed by one idle bubble.
    add(1'b0, 4'hF, 1'b0, D, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0);
    add(1'b0, 4'hF, 1'b0, D, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0);
    add(1'b1, 4'hF, 1'b0, D, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0);
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << order[g];
      for (int b = 0; b < 4; b++)
        add(1'b1, 4'hF, 1'b0, D, oh, 1'b1, sl[order[g]], 1'b1, 2'(order[g]));
      add(1'b1, (g == 4) ? 4'h0 : 4'hF, 1'b0, D, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0);
    end

    drive(1'b0, 4'hF, 1'b0, D);
    adv();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst_n, tbl[i].req, tbl[i].full, tbl[i].data);
      expect_o($sformatf("row%0d", i), tbl[i].gnt, tbl[i].wen, tbl[i].wdata, tbl[i].busy);
      if (tbl[i].busy) chk($sformatf("row%0d_id", i), 32'(bus.gnt_id_o), 32'(tbl[i].id));
      adv();
    end

    // Short burst: requester 2 alone, two words then drops. rr_ptr is 1 here.
    pulses = 0;
    step(1'b1, 4'b0100, 1'b0, 32'h00A5_0000); expect_o("sb1", 4'h0, 1'b0, 8'h00, 1'b0);
    pulses += int'(bus.wen_o); adv();
    step(1'b1, 4'b0100, 1'b0, 32'h00A5_0000); expect_o("sb2", 4'b0100, 1'b1, 8'hA5, 1'b1);
    chk("sb2_id", 32'(bus.gnt_id_o), 32'd2);
    pulses += int'(bus.wen_o); adv();
    step(1'b1, 4'b0100, 1'b0, 32'h005A_0000); expect_o("sb3", 4'b0100, 1'b1, 8'h5A, 1'b1);
    pulses += int'(bus.wen_o); adv();
    step(1'b1, 4'b0000, 1'b0, 32'h005A_0000); expect_o("sb4", 4'b0100, 1'b0, 8'h00, 1'b1);
    pulses += int'(bus.wen_o); adv();
    step(1'b1, 4'b1111, 1'b0, 32'h0);         expect_o("sb5", 4'h0, 1'b0, 8'h00, 1'b0);
    pulses += int'(bus.wen_o); adv();
    chk("sb_pulses", 32'(pulses), 32'd2);
    step(1'b1, 4'b0000, 1'b0, 32'h0);         expect_o("sb6", 4'b1000, 1'b0, 8'h00, 1'b1);
    chk("sb6_id", 32'(bus.gnt_id_o), 32'd3);
    adv();

    // Full stall: holder 1 writes once, stalls 3 cycles, then 3 more writes and forced release.
    step(1'b1, 4'b0010, 1'b0, D); expect_o("fs0", 4'h0, 1'b0, 8'h00, 1'b0); adv();
    step(1'b1, 4'b0010, 1'b0, D); expect_o("fs1", 4'b0010, 1'b1, 8'h22, 1'b1); adv();
    for (int s = 0; s < 3; s++) begin
      step(1'b1, 4'b0010, 1'b1, D); expect_o($sformatf("fs_full%0d", s), 4'b0010, 1'b0, 8'h00, 1'b1); adv();
    end
    for (int s = 0; s < 3; s++) begin
      step(1'b1, 4'b0010, 1'b0, D); expect_o($sformatf("fs_res%0d", s), 4'b0010, 1'b1, 8'h22, 1'b1); adv();
    end
    step(1'b1, 4'b0010, 1'b0, D); expect_o("fs_rel", 4'h0, 1'b0, 8'h00, 1'b0); adv();
    step(1'b1, 4'b0000, 1'b0, D); expect_o("fs_regnt", 4'b0010, 1'b0, 8'h00, 1'b1); adv();
    step(1'b1, 4'b0000, 1'b0, D); expect_o("fs_idle", 4'h0, 1'b0, 8'h00, 1'b0); adv();

    // Reset mid-burst: holder 3 at burst_cnt=2; rr_ptr must return to 0.
    step(1'b1, 4'b1000, 1'b0, D); expect_o("rm0", 4'h0, 1'b0, 8'h00, 1'b0); adv();
    step(1'b1, 4'b1000, 1'b0, D); expect_o("rm1", 4'b1000, 1'b1, 8'h44, 1'b1); adv();
    step(1'b1, 4'b1000, 1'b0, D); expect_o("rm2", 4'b1000, 1'b1, 8'h44, 1'b1); adv();
    step(1'b0, 4'b1000, 1'b0, D); expect_o("rm_rst", 4'b1000, 1'b0, 8'h00, 1'b1); adv();
    step(1'b1, 4'b1001, 1'b0, D); expect_o("rm_after", 4'h0, 1'b0, 8'h00, 1'b0); adv();
    step(1'b1, 4'b0000, 1'b0, D); expect_o("rm_ptr", 4'b0001, 1'b0, 8'h00, 1'b1);
    chk("rm_ptr_id", 32'(bus.gnt_id_o), 32'd0);
    adv();

    // Wrap: requesters 3 and 0 with rr_ptr=1 -> grant 3 then wrap to 0.
    exp_q.push_back('{2'd3, 8'h31}); exp_q.push_back('{2'd3, 8'h32});
    exp_q.push_back('{2'd3, 8'h33}); exp_q.push_back('{2'd3, 8'h34});
    exp_q.push_back('{2'd0, 8'hC6}); exp_q.push_back('{2'd0, 8'hC7});
    exp_q.push_back('{2'd0, 8'hC8}); exp_q.push_back('{2'd0, 8'hC9});
    for (int n = 0; n <= 10; n++) begin
      logic [7:0] d3, d0;
      wr_t        w;
      d3 = 8'h30 + 8'(n);
      d0 = 8'hC0 + 8'(n);
      step(1'b1, (n <= 9) ? 4'b1001 : 4'b0000, 1'b0, {d3, 16'h0000, d0});
      if (bus.wen_o) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("wrap%0d_extra", n), 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          chk($sformatf("wrap%0d_id", n), 32'(bus.gnt_id_o), 32'(w.id));
          chk($sformatf("wrap%0d_data", n), 32'(bus.wdata_o), 32'(w.data));
        end
      end
      adv();
    end
    chk("wrap_left", 32'(exp_q.size()), 32'd0);

    // Requester drops in the same cycle as full: released normally.
    step(1'b1, 4'b0010, 1'b0, D); expect_o("df0", 4'h0, 1'b0, 8'h00, 1'b0); adv();
    step(1'b1, 4'b0010, 1'b0, D); expect_o("df1", 4'b0010, 1'b1, 8'h22, 1'b1); adv();
    step(1'b1, 4'b0000, 1'b1, D); expect_o("df2", 4'b0010, 1'b0, 8'h00, 1'b1); adv();
    step(1'b1, 4'b0000, 1'b0, D); expect_o("df3", 4'h0, 1'b0, 8'h00, 1'b0); adv();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
